// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 scan-code constants, event type and decode helpers.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_D = 8'h23;

    // Bytes that follow E1 in the 8-byte pause sequence.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT_CLR
    } ps2_state_t;

    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            PS2_BAT_OK, PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_ERR0, PS2_ERR1: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] key_mask(input logic [7:0] b);
        case (b)
            KEY_W:   return 4'b0001;
            KEY_S:   return 4'b0010;
            KEY_A:   return 4'b0100;
            KEY_D:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - Synchronous event FIFO; head shown combinationally, zero when empty.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// rtl/ps2_scan_sequencer.sv - PS/2 receiver handshake, multi-byte scan-code assembly,
// event queue and held-key bitmap for the movement keys.
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       scan_ready,
    input  logic [7:0] scan_code,
    output logic       read,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [3:0] key_down,
    output logic       overflow
);

    ps2_state_t state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       read_q, read_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic [3:0] key_down_q, key_down_d;
    logic       overflow_q, overflow_d;

    logic       push;
    ps2_evt_t   push_evt;
    ps2_evt_t   head_evt;
    logic       fifo_full;
    logic       fifo_empty;

    assign push_evt = '{code: byte_q, ext: ext_q, brk: brk_q};

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        read_d     = 1'b0;
        ext_d      = ext_q;
        brk_d      = brk_q;
        skip_d     = skip_q;
        key_down_d = key_down_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_ready) begin
                    byte_d  = scan_code;
                    read_d  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT_CLR;
                if (skip_q != 3'd0) begin
                    skip_d = skip_q - 3'd1;
                end else if (byte_q == PS2_PAUSE) begin
                    skip_d = PAUSE_SKIP;
                    ext_d  = 1'b0;
                    brk_d  = 1'b0;
                end else if (byte_q == PS2_EXT) begin
                    ext_d = 1'b1;
                end else if (byte_q == PS2_BRK) begin
                    brk_d = 1'b1;
                end else if (!is_ignored(byte_q)) begin
                    push = 1'b1;
                    if (!ext_q) begin
                        key_down_d = brk_q ? (key_down_q & ~key_mask(byte_q))
                                           : (key_down_q | key_mask(byte_q));
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
            ST_WAIT_CLR: begin
                if (!scan_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        overflow_d = overflow_q | (push & fifo_full & ~evt_ready);
    end

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_q     <= '0;
            read_q     <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            key_down_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            read_q     <= read_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            key_down_q <= key_down_d;
            overflow_q <= overflow_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(ps2_evt_t))
    ) u_fifo (
        .clk   (clock50),
        .rst   (reset),
        .push  (push),
        .wdata (push_evt),
        .pop   (evt_ready),
        .rdata (head_evt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign read      = read_q;
    assign evt_valid = ~fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_ext   = head_evt.ext;
    assign evt_break = head_evt.brk;
    assign key_down  = key_down_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// tb/tb_ps2_scan_sequencer.sv - Directed self-checking bench for ps2_scan_sequencer.
module tb_ps2_scan_sequencer;

    logic       clock50 = 1'b0;
    logic       reset;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic       read;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [3:0] key_down;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    int         read_cnt = 0;
    logic [9:0] ev_q[$];
    int         rb;
    int         eb;

    ps2_scan_sequencer #(.FIFO_DEPTH(4)) dut (
        .clock50    (clock50),
        .reset      (reset),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .read       (read),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break),
        .key_down   (key_down),
        .overflow   (overflow)
    );

    always #10 clock50 = ~clock50;

    // Record every read pulse and every accepted event as it crosses the edge.
    always @(posedge clock50) begin
        if (read === 1'b1) read_cnt++;
        if (evt_valid === 1'b1 && evt_ready === 1'b1) ev_q.push_back({evt_code, evt_ext, evt_break});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] evw(input logic [7:0] code, input logic ext, input logic brk);
        return {22'b0, code, ext, brk};
    endfunction

    function automatic logic [31:0] ev_at(input int idx);
        if (idx < ev_q.size()) return {22'b0, ev_q[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic wait_read();
        int n;
        n = 0;
        while (read !== 1'b1 && n < 20) begin
            @(negedge clock50);
            n++;
        end
        check("read_timeout", 32'(read === 1'b1), 32'h1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        scan_code  = b;
        scan_ready = 1'b1;
        @(negedge clock50);
        wait_read();
        scan_ready = 1'b0;
        @(negedge clock50);
        @(negedge clock50);
    endtask

    initial begin
        reset      = 1'b1;
        scan_ready = 1'b0;
        scan_code  = 8'h00;
        evt_ready  = 1'b1;
        @(negedge clock50);
        @(negedge clock50);
        check("rst_read",      32'(read),      32'h0);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_evt_code",  32'(evt_code),  32'h0);
        check("rst_evt_ext",   32'(evt_ext),   32'h0);
        check("rst_evt_break", 32'(evt_break), 32'h0);
        check("rst_key_down",  32'(key_down),  32'h0);
        check("rst_overflow",  32'(overflow),  32'h0);
        reset = 1'b0;
        @(negedge clock50);

        // Make then break of W.
        rb = read_cnt; eb = ev_q.size();
        send_byte(8'h1D);
        check("w_held", 32'(key_down), 32'b0001);
        send_byte(8'hF0);
        send_byte(8'h1D);
        check("w_nev",   32'(ev_q.size() - eb), 32'd2);
        check("w_make",  ev_at(eb),     evw(8'h1D, 1'b0, 1'b0));
        check("w_break", ev_at(eb + 1), evw(8'h1D, 1'b0, 1'b1));
        check("w_kd",    32'(key_down), 32'b0000);
        check("w_reads", 32'(read_cnt - rb), 32'd3);

        // Extended make and break.
        rb = read_cnt; eb = ev_q.size();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check("x_nev",   32'(ev_q.size() - eb), 32'd2);
        check("x_make",  ev_at(eb),     evw(8'h75, 1'b1, 1'b0));
        check("x_break", ev_at(eb + 1), evw(8'h75, 1'b1, 1'b1));
        check("x_kd",    32'(key_down), 32'b0000);
        check("x_reads", 32'(read_cnt - rb), 32'd5);

        // Pause sequence swallowed, then A.
        eb = ev_q.size();
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        send_byte(8'h1C);
        check("p_nev", 32'(ev_q.size() - eb), 32'd1);
        check("p_ev",  ev_at(eb), evw(8'h1C, 1'b0, 1'b0));
        check("p_kd",  32'(key_down), 32'b0100);

        // Fill the FIFO, then push and pop in the same cycle.
        evt_ready = 1'b0;
        eb = ev_q.size();
        send_byte(8'h1D); send_byte(8'h1B); send_byte(8'h1C); send_byte(8'h23);
        check("f_valid", 32'(evt_valid), 32'h1);
        check("f_head",  32'(evt_code),  32'h1D);
        check("f_ovf",   32'(overflow),  32'h0);
        check("f_kd",    32'(key_down),  32'b1111);
        scan_code  = 8'h2E;
        scan_ready = 1'b1;
        @(negedge clock50);
        wait_read();
        evt_ready  = 1'b1;
        scan_ready = 1'b0;
        @(negedge clock50);
        evt_ready = 1'b0;
        @(negedge clock50);
        check("pp_nev",  32'(ev_q.size() - eb), 32'd1);
        check("pp_head", 32'(evt_code), 32'h1B);
        check("pp_ovf",  32'(overflow), 32'h0);
        evt_ready = 1'b1;
        repeat (6) @(negedge clock50);
        check("pp_drain_n", 32'(ev_q.size() - eb), 32'd5);
        check("pp_drain_1", ev_at(eb + 1), evw(8'h1B, 1'b0, 1'b0));
        check("pp_drain_4", ev_at(eb + 4), evw(8'h2E, 1'b0, 1'b0));
        check("pp_empty",   32'(evt_valid), 32'h0);
        send_byte(8'hF0); send_byte(8'h1D); send_byte(8'hF0); send_byte(8'h1B);
        send_byte(8'hF0); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h23);
        check("rel_kd", 32'(key_down), 32'b0000);

        // Six makes into a stalled consumer.
        evt_ready = 1'b0;
        eb = ev_q.size();
        send_byte(8'h1D); send_byte(8'h1B); send_byte(8'h1C); send_byte(8'h23);
        check("o_ovf4", 32'(overflow), 32'h0);
        send_byte(8'h29);
        check("o_ovf5", 32'(overflow), 32'h1);
        send_byte(8'h2D);
        check("o_kd",   32'(key_down), 32'b1111);
        check("o_head", 32'(evt_code), 32'h1D);
        evt_ready = 1'b1;
        repeat (6) @(negedge clock50);
        check("o_nev", 32'(ev_q.size() - eb), 32'd4);
        check("o_d0",  ev_at(eb),     evw(8'h1D, 1'b0, 1'b0));
        check("o_d1",  ev_at(eb + 1), evw(8'h1B, 1'b0, 1'b0));
        check("o_d2",  ev_at(eb + 2), evw(8'h1C, 1'b0, 1'b0));
        check("o_d3",  ev_at(eb + 3), evw(8'h23, 1'b0, 1'b0));
        check("o_sticky", 32'(overflow), 32'h1);

        // Reset right after a break prefix, with the next byte already pending.
        send_byte(8'hF0);
        scan_code  = 8'h1B;
        scan_ready = 1'b1;
        reset      = 1'b1;
        #1;
        check("r_read",  32'(read),      32'h0);
        check("r_valid", 32'(evt_valid), 32'h0);
        check("r_kd",    32'(key_down),  32'h0);
        check("r_ovf",   32'(overflow),  32'h0);
        @(negedge clock50);
        @(negedge clock50);
        rb = read_cnt; eb = ev_q.size();
        reset = 1'b0;
        @(negedge clock50);
        wait_read();
        scan_ready = 1'b0;
        @(negedge clock50);
        @(negedge clock50);
        check("r_nev",   32'(ev_q.size() - eb), 32'd1);
        check("r_ev",    ev_at(eb), evw(8'h1B, 1'b0, 1'b0));
        check("r_kd2",   32'(key_down), 32'b0010);
        check("r_reads", 32'(read_cnt - rb), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan_sequencer.md
# ps2_scan_sequencer

Controller between the PS/2 `keyboard` receiver and game logic. It owns the receiver's `read`/`scan_ready` handshake, replacing the external `oneshot`. It assembles multi-byte scan-code sequences (E0 extended prefix, F0 break prefix, E1 pause sequence) into single key events. Events are queued in a 4-entry FIFO with a valid/ready handshake, and a held-key bitmap is maintained for the movement keys.

## Interface
- `FIFO_DEPTH`, 4: event FIFO entries (power of two, ≥2).
- `clock50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `scan_ready`  in  1  from `keyboard`, synchronous to `clock50`; level, held high until `read` is pulsed.
- `scan_code`  in  8  from `keyboard`; stable while `scan_ready` is high.
- `read`  out  1  to `keyboard`; single-cycle acknowledge pulse.
- `evt_valid`  out  1  FIFO head valid.
- `evt_ready`  in  1  consumer accepts head when `evt_valid && evt_ready`.
- `evt_code`  out  8  key code of head event (prefixes stripped).
- `evt_ext`  out  1  head event was E0-prefixed.
- `evt_break`  out  1  head event is a release (F0-prefixed).
- `key_down`  out  4  held state: bit0 W (1D), bit1 S (1B), bit2 A (1C), bit3 D (23); non-extended codes only.
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- Handshake FSM with three states:
  - IDLE: if `scan_ready`, latch `scan_code` and go to ACK.
  - ACK: `read`=1 for this one cycle; decode the latched byte; go to WAIT_CLR.
  - WAIT_CLR: stay until `scan_ready`=0, then go to IDLE. This guarantees exactly one `read` per byte.
- Decode runs in ACK, in priority order:
  - Skip counter nonzero: decrement it and discard the byte.
  - E1: load skip counter with 7 and clear both prefix flags. The pause sequence is discarded entirely.
  - E0: set the ext flag.
  - F0: set the brk flag.
  - AA, FA, EE, FE, 00, FF: discard; flags unchanged.
  - Any other byte: form event {code, ext, brk}, push it to the FIFO, update `key_down`, then clear both flags.
- `key_down` update on a non-extended event whose code is one of the four listed:
  - `brk`=0 sets the bit; `brk`=1 clears it.
  - Extended events never affect `key_down`.
  - `key_down` updates even if the FIFO push is dropped.
- FIFO:
  - Push when not full drops nothing.
  - Push when full drops the new event and sets `overflow`. Exception: a pop in the same cycle makes room, so the push is accepted.
  - Pop when empty is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Reset mid-operation:
  - All state returns to its reset value immediately (async).
  - A byte pending at the receiver is acknowledged after reset like a fresh byte, with prefix flags cleared.

## Timing
- Reset values: `read`=0, `evt_valid`=0, `evt_code`=00, `evt_ext`=0, `evt_break`=0, `key_down`=0000, `overflow`=0. FSM in IDLE, flags and skip counter at 0, FIFO empty.
- `scan_ready` seen high in IDLE at cycle N:
  - `read`=1 during cycle N+1.
  - FIFO write and `key_down` update at the end of N+1.
  - `evt_valid`=1 from N+2 if the FIFO was empty.
- Minimum 3 cycles per byte: IDLE, ACK, and WAIT_CLR for at least one cycle.
- Outputs `evt_*` show the FIFO head combinationally from registered storage. Pop takes effect at the clock edge.
- A 2-byte break sequence (F0 xx) yields one event. A 3-byte extended break sequence (E0 F0 xx) yields one event.

## Structure
- Package `ps2_pkg`:
  - Constants `PS2_EXT`=E0, `PS2_BRK`=F0, `PS2_PAUSE`=E1.
  - Ignore-list constants.
  - `KEY_W`/`KEY_S`/`KEY_A`/`KEY_D` codes.
  - Event struct typedef {code[7:0], ext, brk} (10 bits).
- One sub-module `ps2_evt_fifo`: synchronous FIFO, parameterised depth and width, with push/pop/full/empty.
- The FSM, decode and `key_down` logic stay in the top module.

## Test plan
- Byte 1D then F0 1D, consumer always ready:
  - Events {1D, ext 0, brk 0} then {1D, ext 0, brk 1}.
  - `key_down[0]` is 1 between the two events, then 0.
  - Exactly 3 `read` pulses.
- E0 75 then E0 F0 75: events {75, 1, 0} and {75, 1, 1}; `key_down` stays 0000.
- Pause sequence E1 14 77 E1 F0 14 F0 77 followed by 1C: only event {1C, 0, 0}; `key_down[2]`=1.
- `evt_ready`=0, six make codes 1D 1B 1C 23 29 2D:
  - FIFO holds the first 4 codes; `overflow`=1.
  - `key_down`=1111.
  - Draining yields 1D 1B 1C 23, in that order.
- FIFO full with a push and pop in the same cycle: push accepted, occupancy stays 4, `overflow` unchanged.
- Assert `reset` in the cycle after an F0 byte:
  - All outputs return to reset values.
  - The next byte 1B yields a make event {1B, 0, 0}, not a break.
  - `scan_ready` held high across reset produces one `read`.
